// File: rtl/alu_pkg.sv
// Shared definitions for the ALU operand/result interface.
//   ALU_OP_W : op-code width driven into the ALU
//   DONE_W   : width of the completed-operation counter
//   alu_op_e : op-code values (AND..MOD)
//   state_e  : issue controller state encoding
package alu_pkg;

  localparam int unsigned ALU_OP_W = 3;
  localparam int unsigned DONE_W   = 16;

  typedef enum logic [ALU_OP_W-1:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_XOR  = 3'd2,
    OP_NOR  = 3'd3,
    OP_LESS = 3'd4,
    OP_ADD  = 3'd5,
    OP_SUB  = 3'd6,
    OP_MOD  = 3'd7
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

endpackage

// File: rtl/alu_watchdog.sv
// Loadable-clear cycle counter that flags when TIMEOUT-1 increments have
// been counted since the last clear.
//   clk_i     : clock
//   rst_i     : synchronous active-high reset
//   clr_i     : clear counter to zero (wins over inc_i)
//   inc_i     : count one cycle
//   expired_o : registered, high while the count equals TIMEOUT-1
module alu_watchdog #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q;

  // Next count
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Expiry is computed from the next count so it is registered yet aligned
  // with the counter value it describes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= (cnt_d == CNT_W'(TIMEOUT - 1));
    end
  end

  assign expired_o = expired_q;

endmodule

// File: rtl/alu_issue_ctrl.sv
// Initiator side of the ALU operand/result interface. Accepts tagged
// requests, holds operands on the ALU until We, and returns result/carry/tag
// (or a timeout error) on a valid/ready response port.
//   Clk, Reset              : clock, synchronous active-high reset
//   ReqValid/ReqReady/Req*  : request port (ReqReady combinational)
//   AluA/AluB/AluOp         : operands and op to the ALU, change only on accept
//   AluResult/AluC/AluWe    : ALU result, carry-out, result valid
//   RspValid/RspReady/Rsp*  : response port
//   DoneCount               : completed non-error operations (wrapping)
module alu_issue_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                ReqValid,
  output logic                ReqReady,
  input  logic [WIDTH-1:0]    ReqA,
  input  logic [WIDTH-1:0]    ReqB,
  input  logic [ALU_OP_W-1:0] ReqOp,
  input  logic [TAG_W-1:0]    ReqTag,
  output logic [WIDTH-1:0]    AluA,
  output logic [WIDTH-1:0]    AluB,
  output logic [ALU_OP_W-1:0] AluOp,
  input  logic [WIDTH-1:0]    AluResult,
  input  logic                AluC,
  input  logic                AluWe,
  output logic                RspValid,
  input  logic                RspReady,
  output logic [WIDTH-1:0]    RspResult,
  output logic                RspCarry,
  output logic                RspErr,
  output logic [TAG_W-1:0]    RspTag,
  output logic [DONE_W-1:0]   DoneCount
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    alu_a_q, alu_a_d;
  logic [WIDTH-1:0]    alu_b_q, alu_b_d;
  logic [ALU_OP_W-1:0] alu_op_q, alu_op_d;
  logic [TAG_W-1:0]    tag_q, tag_d;
  logic [WIDTH-1:0]    rsp_result_q, rsp_result_d;
  logic                rsp_carry_q, rsp_carry_d;
  logic                rsp_err_q, rsp_err_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [DONE_W-1:0]   done_q, done_d;
  logic                req_ready_c;
  logic                wd_clr, wd_inc, wd_expired;

  alu_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk_i     (Clk),
    .rst_i     (Reset),
    .clr_i     (wd_clr),
    .inc_i     (wd_inc),
    .expired_o (wd_expired)
  );

  // Next-state and datapath control
  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    tag_d        = tag_q;
    rsp_result_d = rsp_result_q;
    rsp_carry_d  = rsp_carry_q;
    rsp_err_d    = rsp_err_q;
    done_d       = done_q;
    req_ready_c  = 1'b0;
    wd_clr       = 1'b0;
    wd_inc       = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready_c = 1'b1;
        if (ReqValid) begin
          alu_a_d  = ReqA;
          alu_b_d  = ReqB;
          alu_op_d = ReqOp;
          tag_d    = ReqTag;
          state_d  = ST_ISSUE;
        end
      end
      // One-cycle slot: a We still high from the previous operand set is
      // deliberately not looked at here.
      ST_ISSUE: begin
        wd_clr  = 1'b1;
        state_d = ST_WAIT;
      end
      // We has priority over a coincident watchdog expiry.
      ST_WAIT: begin
        if (AluWe) begin
          rsp_result_d = AluResult;
          rsp_carry_d  = AluC;
          rsp_err_d    = 1'b0;
          done_d       = done_q + DONE_W'(1);
          state_d      = ST_RESP;
        end else if (wd_expired) begin
          rsp_result_d = '0;
          rsp_carry_d  = 1'b0;
          rsp_err_d    = 1'b1;
          state_d      = ST_RESP;
        end else begin
          wd_inc = 1'b1;
        end
      end
      // Response consumed: bypass straight into a new issue if one is waiting.
      ST_RESP: begin
        if (RspReady) begin
          req_ready_c = 1'b1;
          if (ReqValid) begin
            alu_a_d  = ReqA;
            alu_b_d  = ReqB;
            alu_op_d = ReqOp;
            tag_d    = ReqTag;
            state_d  = ST_ISSUE;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    rsp_valid_d = (state_d == ST_RESP);
  end

  // State and output registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= ST_IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_carry_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_valid_q  <= 1'b0;
      done_q       <= '0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      tag_q        <= tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_carry_q  <= rsp_carry_d;
      rsp_err_q    <= rsp_err_d;
      rsp_valid_q  <= rsp_valid_d;
      done_q       <= done_d;
    end
  end

  assign ReqReady  = req_ready_c;
  assign AluA      = alu_a_q;
  assign AluB      = alu_b_q;
  assign AluOp     = alu_op_q;
  assign RspValid  = rsp_valid_q;
  assign RspResult = rsp_result_q;
  assign RspCarry  = rsp_carry_q;
  assign RspErr    = rsp_err_q;
  assign RspTag    = tag_q;
  assign DoneCount = done_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed bench for alu_issue_ctrl with a behavioural ALU stand-in.
module tb_alu_issue_ctrl;
  import alu_pkg::*;

  localparam int unsigned WIDTH   = 32;
  localparam int unsigned TAG_W   = 4;
  localparam int unsigned TIMEOUT = 8;

  logic                Clk, Reset;
  logic                ReqValid, ReqReady;
  logic [WIDTH-1:0]    ReqA, ReqB;
  logic [ALU_OP_W-1:0] ReqOp;
  logic [TAG_W-1:0]    ReqTag;
  logic [WIDTH-1:0]    AluA, AluB;
  logic [ALU_OP_W-1:0] AluOp;
  logic [WIDTH-1:0]    AluResult;
  logic                AluC, AluWe;
  logic                RspValid, RspReady;
  logic [WIDTH-1:0]    RspResult;
  logic                RspCarry, RspErr;
  logic [TAG_W-1:0]    RspTag;
  logic [15:0]         DoneCount;

  int checks = 0;
  int errors = 0;

  alu_issue_ctrl #(
    .WIDTH   (WIDTH),
    .TAG_W   (TAG_W),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .ReqValid  (ReqValid),
    .ReqReady  (ReqReady),
    .ReqA      (ReqA),
    .ReqB      (ReqB),
    .ReqOp     (ReqOp),
    .ReqTag    (ReqTag),
    .AluA      (AluA),
    .AluB      (AluB),
    .AluOp     (AluOp),
    .AluResult (AluResult),
    .AluC      (AluC),
    .AluWe     (AluWe),
    .RspValid  (RspValid),
    .RspReady  (RspReady),
    .RspResult (RspResult),
    .RspCarry  (RspCarry),
    .RspErr    (RspErr),
    .RspTag    (RspTag),
    .DoneCount (DoneCount)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // ALU stand-in: combinational result, We after 1 cycle (4 for MOD), and a
  // stale We carried into the ISSUE cycle that the controller must ignore.
  logic       busy_q, stale_q, stuck, alu_done;
  logic [3:0] lat_q;
  logic [32:0] sum33, dif33;

  assign alu_done = busy_q && (lat_q == 4'd0);
  assign AluWe    = !stuck && (alu_done || stale_q);

  always_ff @(posedge Clk) begin
    if (Reset) begin
      busy_q  <= 1'b0;
      stale_q <= 1'b0;
      lat_q   <= 4'd0;
    end else if (ReqValid && ReqReady) begin
      busy_q  <= 1'b1;
      stale_q <= alu_done;
      lat_q   <= (ReqOp == OP_MOD) ? 4'd4 : 4'd1;
    end else begin
      stale_q <= 1'b0;
      if (lat_q != 4'd0) lat_q <= lat_q - 4'd1;
    end
  end

  always_comb begin
    sum33     = {1'b0, AluA} + {1'b0, AluB};
    dif33     = {1'b0, AluA} - {1'b0, AluB};
    AluResult = '0;
    AluC      = 1'b0;
    case (AluOp)
      OP_AND:  AluResult = AluA & AluB;
      OP_OR:   AluResult = AluA | AluB;
      OP_XOR:  AluResult = AluA ^ AluB;
      OP_NOR:  AluResult = ~(AluA | AluB);
      OP_LESS: AluResult = ($signed(AluA) < $signed(AluB)) ? 32'd1 : 32'd0;
      OP_ADD:  begin AluResult = sum33[31:0]; AluC = sum33[32]; end
      OP_SUB:  begin AluResult = dif33[31:0]; AluC = dif33[32]; end
      default: AluResult = (AluB == 32'd0) ? 32'd0 : AluA % AluB;
    endcase
  end

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [2:0]  op;
    logic [3:0]  tag;
    logic [31:0] res;
    logic        c;
    logic        err;
    int          lat;
  } vec_t;

  localparam int NVEC = 14;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic [31:0] a, input logic [31:0] b,
                              input logic [2:0] op, input logic [3:0] tag,
                              input logic [31:0] res, input logic c,
                              input logic err, input int lat);
    vec_t v;
    v.a = a; v.b = b; v.op = op; v.tag = tag;
    v.res = res; v.c = c; v.err = err; v.lat = lat;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Present a request from a negedge; returns #1 after the accepting posedge.
  task automatic send_req(input vec_t v);
    bit acc;
    acc = 1'b0;
    ReqValid = 1'b1; ReqA = v.a; ReqB = v.b; ReqOp = v.op; ReqTag = v.tag;
    for (int k = 0; k < 50 && !acc; k++) begin
      #1;
      if (ReqReady) begin
        @(posedge Clk);
        acc = 1'b1;
      end else begin
        @(negedge Clk);
      end
    end
    #1 ReqValid = 1'b0;
    chk($sformatf("accept tag%0d", v.tag), 32'(acc), 32'd1);
  endtask

  // Count negedges from the accepting edge until RspValid, checking the ALU
  // side stays frozen meanwhile, then compare the response.
  task automatic await_rsp(input vec_t v);
    int lat;
    bit got, stable;
    lat = 0; got = 1'b0; stable = 1'b1;
    for (int k = 0; k < 40 && !got; k++) begin
      @(negedge Clk);
      lat++;
      if (RspValid) got = 1'b1;
      else if (AluA !== v.a || AluB !== v.b || AluOp !== v.op || ReqReady !== 1'b0)
        stable = 1'b0;
    end
    chk($sformatf("rsp_valid tag%0d", v.tag), 32'(got), 32'd1);
    chk($sformatf("result tag%0d", v.tag), RspResult, v.res);
    chk($sformatf("carry tag%0d", v.tag), 32'(RspCarry), 32'(v.c));
    chk($sformatf("err tag%0d", v.tag), 32'(RspErr), 32'(v.err));
    chk($sformatf("tag tag%0d", v.tag), 32'(RspTag), 32'(v.tag));
    chk($sformatf("latency tag%0d", v.tag), 32'(lat), 32'(v.lat));
    chk($sformatf("alu_hold tag%0d", v.tag), 32'(stable), 32'd1);
  endtask

  task automatic consume();
    RspReady = 1'b1;
    @(posedge Clk);
    #1 RspReady = 1'b0;
    @(negedge Clk);
  endtask

  task automatic run_op(input vec_t v);
    send_req(v);
    await_rsp(v);
    consume();
  endtask

  vec_t vb, vs, vt, vm, va;
  bit   ok;
  logic [15:0] done_before;

  initial begin
    vecs[0]  = mk(32'd1,          32'd100,        OP_LESS, 4'd0,  32'd1,          1'b0, 1'b0, 3);
    vecs[1]  = mk(32'd500,        32'd333,        OP_LESS, 4'd1,  32'd0,          1'b0, 1'b0, 3);
    vecs[2]  = mk(-32'sd100,      -32'sd300,      OP_LESS, 4'd2,  32'd0,          1'b0, 1'b0, 3);
    vecs[3]  = mk(-32'sd500,      -32'sd300,      OP_LESS, 4'd3,  32'd1,          1'b0, 1'b0, 3);
    vecs[4]  = mk(32'hFFFF_FFFF,  32'd100,        OP_LESS, 4'd4,  32'd1,          1'b0, 1'b0, 3);
    vecs[5]  = mk(32'd5,          32'd7,          OP_ADD,  4'd3,  32'd12,         1'b0, 1'b0, 3);
    vecs[6]  = mk(32'd16,         32'd5,          OP_MOD,  4'd5,  32'd1,          1'b0, 1'b0, 6);
    vecs[7]  = mk(32'd42,         32'd11,         OP_MOD,  4'd6,  32'd9,          1'b0, 1'b0, 6);
    vecs[8]  = mk(32'hFFFF_FFFF,  32'd1,          OP_ADD,  4'd7,  32'd0,          1'b1, 1'b0, 3);
    vecs[9]  = mk(32'd10,         32'd3,          OP_SUB,  4'd8,  32'd7,          1'b0, 1'b0, 3);
    vecs[10] = mk(32'hF0F0_F0F0,  32'hFF00_FF00,  OP_XOR,  4'd9,  32'h0FF0_0FF0,  1'b0, 1'b0, 3);
    vecs[11] = mk(32'h0000_FFFF,  32'h00FF_0000,  OP_NOR,  4'd10, 32'hFF00_0000,  1'b0, 1'b0, 3);
    vecs[12] = mk(32'h0000_F0F0,  32'h0000_FF00,  OP_AND,  4'd11, 32'h0000_F000,  1'b0, 1'b0, 3);
    vecs[13] = mk(32'h0000_0001,  32'h8000_0000,  OP_OR,   4'd12, 32'h8000_0001,  1'b0, 1'b0, 3);

    Reset = 1'b1; ReqValid = 1'b0; ReqA = '0; ReqB = '0; ReqOp = '0; ReqTag = '0;
    RspReady = 1'b0; stuck = 1'b0;
    repeat (3) @(negedge Clk);

    // Reset values
    chk("rst AluA", AluA, 32'd0);
    chk("rst AluB", AluB, 32'd0);
    chk("rst AluOp", 32'(AluOp), 32'd0);
    chk("rst RspValid", 32'(RspValid), 32'd0);
    chk("rst RspResult", RspResult, 32'd0);
    chk("rst RspErr", 32'(RspErr), 32'd0);
    chk("rst RspTag", 32'(RspTag), 32'd0);
    chk("rst DoneCount", 32'(DoneCount), 32'd0);
    Reset = 1'b0;
    #1 chk("ReqReady after reset", 32'(ReqReady), 32'd1);
    @(negedge Clk);

    // Table-driven operations
    for (int i = 0; i < NVEC; i++) begin
      run_op(vecs[i]);
      if (i == 4) chk("DoneCount after LESS seq", 32'(DoneCount), 32'd5);
    end
    chk("DoneCount after table", 32'(DoneCount), 32'(NVEC));

    // Backpressure for 10 cycles, then bypass into SUB 10,3
    vb = mk(32'h0000_F0F0, 32'h0000_FF00, OP_AND, 4'd13, 32'h0000_F000, 1'b0, 1'b0, 3);
    vs = mk(32'd10,        32'd3,         OP_SUB, 4'd14, 32'd7,         1'b0, 1'b0, 3);
    send_req(vb);
    await_rsp(vb);
    ReqValid = 1'b1; ReqA = vs.a; ReqB = vs.b; ReqOp = vs.op; ReqTag = vs.tag;
    ok = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (RspValid !== 1'b1 || RspResult !== vb.res || RspTag !== vb.tag ||
          RspErr !== 1'b0 || ReqReady !== 1'b0 || AluA !== vb.a || AluOp !== vb.op)
        ok = 1'b0;
      @(negedge Clk);
    end
    chk("backpressure hold", 32'(ok), 32'd1);
    RspReady = 1'b1;
    #1 chk("bypass ReqReady", 32'(ReqReady), 32'd1);
    @(posedge Clk);
    #1 begin RspReady = 1'b0; ReqValid = 1'b0; end
    await_rsp(vs);
    consume();
    chk("DoneCount after bypass", 32'(DoneCount), 32'(NVEC + 2));

    // Timeout with We stuck low
    stuck = 1'b1;
    done_before = DoneCount;
    vt = mk(32'hFFFF_FFFF, 32'd1, OP_ADD, 4'd15, 32'd0, 1'b0, 1'b1, TIMEOUT + 2);
    run_op(vt);
    chk("DoneCount unchanged on timeout", 32'(DoneCount), 32'(done_before));
    stuck = 1'b0;

    // Reset in the middle of a MOD wait
    vm = mk(32'd100, 32'd7, OP_MOD, 4'd2, 32'd2, 1'b0, 1'b0, 6);
    send_req(vm);
    repeat (3) @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    chk("mid rst AluA", AluA, 32'd0);
    chk("mid rst AluB", AluB, 32'd0);
    chk("mid rst AluOp", 32'(AluOp), 32'd0);
    chk("mid rst RspValid", 32'(RspValid), 32'd0);
    chk("mid rst RspErr", 32'(RspErr), 32'd0);
    chk("mid rst RspCarry", 32'(RspCarry), 32'd0);
    chk("mid rst RspTag", 32'(RspTag), 32'd0);
    chk("mid rst DoneCount", 32'(DoneCount), 32'd0);
    Reset = 1'b0;
    #1 chk("mid rst ReqReady", 32'(ReqReady), 32'd1);
    ok = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      if (RspValid !== 1'b0) ok = 1'b0;
    end
    chk("no response after reset", 32'(ok), 32'd1);
    va = mk(32'd1, 32'd1, OP_ADD, 4'd1, 32'd2, 1'b0, 1'b0, 3);
    run_op(va);
    chk("DoneCount after reset op", 32'(DoneCount), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time bound so the bench always terminates.
  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

endmodule
